// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_defs (package)
//  Purpose  : Shared definitions for the write-back stage: MEM->WB bus layout,
//             CP0 register addresses, ExcCode values, reset/vector constants
//             and CP0 write masks.
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_defs;

  localparam int MEM_WB_W = 122;

  // Field order is MSB first, so a packed cast of the raw bus unpacks it.
  typedef struct packed {
    logic        rf_wen;
    logic [4:0]  rf_wdest;
    logic [31:0] mem_result;
    logic [31:0] lo_result;
    logic        hi_write;
    logic        lo_write;
    logic        mfhi;
    logic        mflo;
    logic        mtc0;
    logic        mfc0;
    logic [7:0]  cp0r_addr;
    logic        syscall;
    logic        eret;
    logic        fetch_error;
    logic        raddr_error;
    logic        waddr_error;
    logic        overflow;
    logic [31:0] pc;
  } mem_wb_bus_t;

  // CP0 addresses are {rd, sel}
  localparam logic [7:0] CP0_BADVADDR = 8'h40;
  localparam logic [7:0] CP0_COUNT    = 8'h48;
  localparam logic [7:0] CP0_STATUS   = 8'h60;
  localparam logic [7:0] CP0_CAUSE    = 8'h68;
  localparam logic [7:0] CP0_EPC      = 8'h70;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;
  localparam logic [31:0] STATUS_RST_DEF = 32'h0040_0000;

  // Software-writable bits: Status IM[15:8], EXL[1], IE[0]; Cause IP[9:8]
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

  function automatic mem_wb_bus_t unpack_bus(input logic [MEM_WB_W-1:0] raw);
    return mem_wb_bus_t'(raw);
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_if.sv
`default_nettype none
// ============================================================================
//  Module   : wb_if (interface)
//  Purpose  : Bundles the MEM->WB inputs and the write-back results.
//  Ports    : master - upstream/testbench side: drives WB_valid, MEM_WB_bus_r,
//                      mem_badvaddr; receives all WB results.
//             slave  - write-back stage side (mirror of master).
//  Revision : 1.0 - initial release
// ============================================================================
interface wb_if;
  import cpu_defs::*;

  logic                WB_valid;
  logic [MEM_WB_W-1:0] MEM_WB_bus_r;
  logic [31:0]         mem_badvaddr;

  logic                rf_wen;
  logic [4:0]          rf_wdest;
  logic [31:0]         rf_wdata;
  logic                WB_over;
  logic [4:0]          WB_wdest;
  logic                cancel;
  logic                exc_pc_valid;
  logic [31:0]         exc_pc;
  logic [31:0]         WB_pc;
  logic [31:0]         HI_data;
  logic [31:0]         LO_data;

  modport master (
    output WB_valid, MEM_WB_bus_r, mem_badvaddr,
    input  rf_wen, rf_wdest, rf_wdata, WB_over, WB_wdest, cancel,
           exc_pc_valid, exc_pc, WB_pc, HI_data, LO_data
  );

  modport slave (
    input  WB_valid, MEM_WB_bus_r, mem_badvaddr,
    output rf_wen, rf_wdest, rf_wdata, WB_over, WB_wdest, cancel,
           exc_pc_valid, exc_pc, WB_pc, HI_data, LO_data
  );

endinterface
`default_nettype wire

// File: rtl/wb_cp0_regs.sv
`default_nettype none
// ============================================================================
//  Module   : cp0_regs
//  Purpose  : CP0 subset - Status, Cause, EPC, BadVAddr, Count (+ half-rate
//             tick), read mux, mtc0 writes, exception and ERET updates.
//  Ports    : clk, resetn       - clock, synchronous active-low reset
//             i_mtc0            - qualified mtc0 write strobe
//             i_addr, i_wdata   - CP0 address {rd,sel} and mtc0 data
//             i_exc, i_exc_code - qualified exception strobe and ExcCode
//             i_badv_load/val   - BadVAddr capture strobe and value
//             i_pc              - pc of the excepting instruction
//             i_eret            - qualified ERET strobe
//             o_rdata           - read data for i_addr (0 if unmapped)
//             o_epc             - current EPC
//  Revision : 1.0 - initial release
// ============================================================================
module cp0_regs
  import cpu_defs::*;
#(
  parameter logic [31:0] STATUS_RST = STATUS_RST_DEF
) (
  input  wire logic        clk,
  input  wire logic        resetn,
  input  wire logic        i_mtc0,
  input  wire logic [7:0]  i_addr,
  input  wire logic [31:0] i_wdata,
  input  wire logic        i_exc,
  input  wire logic [4:0]  i_exc_code,
  input  wire logic        i_badv_load,
  input  wire logic [31:0] i_badv_val,
  input  wire logic [31:0] i_pc,
  input  wire logic        i_eret,
  output logic [31:0]      o_rdata,
  output logic [31:0]      o_epc
);

  logic [31:0] r_status;
  logic [31:0] r_cause;
  logic [31:0] r_epc;
  logic [31:0] r_badvaddr;
  logic [31:0] r_count;
  logic        r_tick;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_status   <= STATUS_RST;
      r_cause    <= 32'd0;
      r_epc      <= 32'd0;
      r_badvaddr <= 32'd0;
      r_count    <= 32'd0;
      r_tick     <= 1'b0;
    end else begin
      // Count advances on every second clock
      r_tick <= ~r_tick;
      if (r_tick) begin
        r_count <= r_count + 32'd1;
      end

      // Later assignments below take precedence (mtc0 Count beats increment)
      if (i_mtc0) begin
        case (i_addr)
          CP0_STATUS: r_status <= (r_status & ~STATUS_WMASK) | (i_wdata & STATUS_WMASK);
          CP0_CAUSE:  r_cause  <= (r_cause  & ~CAUSE_WMASK)  | (i_wdata & CAUSE_WMASK);
          CP0_EPC:    r_epc    <= i_wdata;
          CP0_COUNT: begin
            r_count <= i_wdata;
            r_tick  <= 1'b0;
          end
          default: ;
        endcase
      end

      if (i_exc) begin
        // Nested exceptions keep the original return address
        if (!r_status[1]) begin
          r_epc <= i_pc;
        end
        r_cause[6:2] <= i_exc_code;
        r_status[1]  <= 1'b1;
        if (i_badv_load) begin
          r_badvaddr <= i_badv_val;
        end
      end

      if (i_eret) begin
        r_status[1] <= 1'b0;
      end
    end
  end

  always_comb begin
    o_rdata = 32'd0;
    case (i_addr)
      CP0_STATUS:   o_rdata = r_status;
      CP0_CAUSE:    o_rdata = r_cause;
      CP0_EPC:      o_rdata = r_epc;
      CP0_BADVADDR: o_rdata = r_badvaddr;
      CP0_COUNT:    o_rdata = r_count;
      default:      o_rdata = 32'd0;
    endcase
  end

  assign o_epc = r_epc;

endmodule
`default_nettype wire

// File: rtl/wb.sv
`default_nettype none
// ============================================================================
//  Module   : wb
//  Purpose  : Write-back stage. Unpacks the MEM->WB bus, selects register
//             file write data, owns HI/LO and the CP0 subset, detects precise
//             exceptions / ERET and issues a one-cycle cancel + redirect.
//  Ports    : clk    - system clock
//             resetn - synchronous active-low reset
//             io     - wb_if.slave: WB_valid, MEM_WB_bus_r, mem_badvaddr in;
//                      rf_wen/rf_wdest/rf_wdata, WB_over, WB_wdest, cancel,
//                      exc_pc_valid, exc_pc, WB_pc, HI_data, LO_data out
//  Revision : 1.0 - initial release
// ============================================================================
module wb
  import cpu_defs::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter logic [31:0] STATUS_RST = STATUS_RST_DEF
) (
  input wire logic clk,
  input wire logic resetn,
  wb_if.slave      io
);

  mem_wb_bus_t w_bus;
  logic        w_exc;
  logic        w_eret;
  logic        w_mtc0;
  logic [4:0]  w_exc_code;
  logic        w_badv_load;
  logic [31:0] w_badv_val;
  logic [31:0] w_cp0_rdata;
  logic [31:0] w_epc;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  assign w_bus = unpack_bus(io.MEM_WB_bus_r);

  assign w_exc  = io.WB_valid & (w_bus.fetch_error | w_bus.overflow | w_bus.syscall |
                                 w_bus.raddr_error | w_bus.waddr_error);
  assign w_eret = io.WB_valid & w_bus.eret & ~w_exc;
  assign w_mtc0 = io.WB_valid & w_bus.mtc0 & ~w_exc;

  // Priority encoder; BadVAddr is captured only when an address cause wins
  always_comb begin
    w_exc_code  = EXC_ADES;
    w_badv_load = 1'b0;
    w_badv_val  = io.mem_badvaddr;
    if (w_bus.fetch_error) begin
      w_exc_code  = EXC_ADEL;
      w_badv_load = 1'b1;
      w_badv_val  = w_bus.pc;
    end else if (w_bus.syscall) begin
      w_exc_code  = EXC_SYS;
    end else if (w_bus.overflow) begin
      w_exc_code  = EXC_OV;
    end else if (w_bus.raddr_error) begin
      w_exc_code  = EXC_ADEL;
      w_badv_load = 1'b1;
    end else if (w_bus.waddr_error) begin
      w_exc_code  = EXC_ADES;
      w_badv_load = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else begin
      if (io.WB_valid && w_bus.hi_write && !w_exc) begin
        r_hi <= w_bus.mem_result;
      end
      if (io.WB_valid && w_bus.lo_write && !w_exc) begin
        r_lo <= w_bus.lo_result;
      end
    end
  end

  cp0_regs #(
    .STATUS_RST (STATUS_RST)
  ) u_cp0 (
    .clk         (clk),
    .resetn      (resetn),
    .i_mtc0      (w_mtc0),
    .i_addr      (w_bus.cp0r_addr),
    .i_wdata     (w_bus.mem_result),
    .i_exc       (w_exc),
    .i_exc_code  (w_exc_code),
    .i_badv_load (w_badv_load),
    .i_badv_val  (w_badv_val),
    .i_pc        (w_bus.pc),
    .i_eret      (w_eret),
    .o_rdata     (w_cp0_rdata),
    .o_epc       (w_epc)
  );

  // mfhi/mflo read the pre-edge HI/LO values
  always_comb begin
    io.rf_wdata = w_bus.mem_result;
    if (w_bus.mfhi) begin
      io.rf_wdata = r_hi;
    end else if (w_bus.mflo) begin
      io.rf_wdata = r_lo;
    end else if (w_bus.mfc0) begin
      io.rf_wdata = w_cp0_rdata;
    end
  end

  assign io.rf_wen       = io.WB_valid & w_bus.rf_wen & ~w_exc;
  assign io.rf_wdest     = w_bus.rf_wdest;
  assign io.WB_over      = io.WB_valid;
  assign io.WB_wdest     = w_bus.rf_wdest & {5{io.WB_valid}};
  assign io.cancel       = w_exc | w_eret;
  assign io.exc_pc_valid = w_exc | w_eret;
  assign io.exc_pc       = w_exc ? EXC_VECTOR : w_epc;
  assign io.WB_pc        = w_bus.pc;
  assign io.HI_data      = r_hi;
  assign io.LO_data      = r_lo;

endmodule
`default_nettype wire
